// File: rtl/jtgng_sdram_pkg.sv
// Shared SDRAM arbiter types and defaults; also imported by the SDRAM controller bench.
package jtgng_sdram_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RFSH} state_e;
  typedef enum logic [1:0] {GT_NONE, GT_STARVE, GT_C0, GT_RR} gtype_e;

  localparam logic [7:0] STARVE_DEF = 8'd64;
  localparam logic [7:0] TOUT_DEF   = 8'd32;
  // Refresh window counter value at which a pending refresh beats client traffic
  localparam logic [6:0] RFSH_FORCE = 7'd63;

  function automatic logic [2:0] oh2idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/jtgng_sdram_arb_if.sv
// Arbiter-to-SDRAM-controller request/data bus.
interface jtgng_sdram_arb_if #(parameter int AW = 22);
  logic          sdram_req;
  logic [AW-1:0] sdram_addr;
  logic          sdram_ack;
  logic          data_rdy;
  logic [31:0]   data_read;
  logic          rfsh_req;

  modport master (output sdram_req, sdram_addr, rfsh_req,
                  input  sdram_ack, data_rdy, data_read);
  modport slave  (input  sdram_req, sdram_addr, rfsh_req,
                  output sdram_ack, data_rdy, data_read);
endinterface

// File: rtl/jtgng_arb_pick.sv
// Combinational winner selection: starving clients, then client 0, then round-robin over 1..NC-1.
module jtgng_arb_pick
  import jtgng_sdram_pkg::*;
#(
  parameter int NC = 4
) (
  input  logic [NC-1:0] req,
  input  logic [NC-1:0] starve,
  input  logic [2:0]    ptr,
  output logic [NC-1:0] grant,
  output gtype_e        gtype
);

  logic [NC-1:0] hungry;
  int            cand;

  assign hungry = req & starve;

  always_comb begin
    grant = '0;
    gtype = GT_NONE;
    cand  = 0;
    for (int i = 0; i < NC; i++) begin
      if (gtype == GT_NONE && hungry[i]) begin
        grant[i] = 1'b1;
        gtype    = GT_STARVE;
      end
    end
    if (gtype == GT_NONE && req[0]) begin
      grant[0] = 1'b1;
      gtype    = GT_C0;
    end
    // Search starts after the last round-robin winner and wraps NC-1 -> 1
    for (int k = 1; k < NC; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NC) cand = cand - (NC - 1);
      for (int j = 1; j < NC; j++) begin
        if (gtype == GT_NONE && j == cand && req[j]) begin
          grant[j] = 1'b1;
          gtype    = GT_RR;
        end
      end
    end
  end

endmodule

// File: rtl/jtgng_sdram_arb.sv
// ROM-client arbiter in front of the SDRAM controller: one access in flight, refresh in vblank,
// starvation override and a data timeout watchdog.
module jtgng_sdram_arb
  import jtgng_sdram_pkg::*;
#(
  parameter int         NC     = 4,
  parameter int         AW     = 22,
  parameter logic [7:0] STARVE = STARVE_DEF,
  parameter logic [7:0] TOUT   = TOUT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             refresh_en,
  input  logic [NC-1:0]    cl_req,
  input  logic [NC*AW-1:0] cl_addr,
  output logic [NC-1:0]    cl_ok,
  output logic [31:0]      dout,
  output logic             timeout_err,
  jtgng_sdram_arb_if.master sd
);

  state_e        state_q, state_d;
  logic [NC-1:0] grant_q, grant_d, cl_ok_q, cl_ok_d;
  logic [2:0]    ptr_q, ptr_d;
  logic [AW-1:0] addr_q, addr_d, pick_addr;
  logic          sdram_req_q, sdram_req_d, rfsh_req_q, rfsh_req_d;
  logic          timeout_q, timeout_d;
  logic [31:0]   dout_q, dout_d;
  logic [7:0]    tcnt_q, tcnt_d;
  logic [6:0]    rwin_q, rwin_d;
  logic [NC-1:0] starve, pick_grant;
  gtype_e        pick_type;
  logic          do_grant, do_rfsh, tout_hit;

  jtgng_arb_pick #(.NC(NC)) u_pick (
    .req    (cl_req),
    .starve (starve),
    .ptr    (ptr_q),
    .grant  (pick_grant),
    .gtype  (pick_type)
  );

  for (genvar gi = 0; gi < NC; gi++) begin : g_wait
    logic [7:0] wcnt_q, wcnt_d;
    always_comb begin
      wcnt_d = wcnt_q;
      if (flush || !cl_req[gi] || (do_grant && pick_grant[gi])) wcnt_d = '0;
      else if (wcnt_q != 8'hFF) wcnt_d = wcnt_q + 8'd1;
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) wcnt_q <= '0;
      else        wcnt_q <= wcnt_d;
    end
    assign starve[gi] = (wcnt_q >= STARVE);
  end

  always_comb begin
    pick_addr = '0;
    for (int i = 0; i < NC; i++) begin
      if (pick_grant[i]) pick_addr = cl_addr[i*AW +: AW];
    end
  end

  // Starving clients beat refresh; refresh beats other clients only once the window is old
  always_comb begin
    do_grant = 1'b0;
    do_rfsh  = 1'b0;
    if (state_q == ST_IDLE && !flush) begin
      if (pick_type == GT_STARVE) do_grant = 1'b1;
      else if (refresh_en && (cl_req == '0 || rwin_q >= RFSH_FORCE)) do_rfsh = 1'b1;
      else if (pick_type != GT_NONE) do_grant = 1'b1;
    end
  end

  assign tout_hit = (tcnt_q == TOUT - 8'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      cl_ok_q     <= '0;
      ptr_q       <= '0;
      addr_q      <= '0;
      sdram_req_q <= 1'b0;
      rfsh_req_q  <= 1'b0;
      timeout_q   <= 1'b0;
      dout_q      <= '0;
      tcnt_q      <= '0;
      rwin_q      <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      cl_ok_q     <= cl_ok_d;
      ptr_q       <= ptr_d;
      addr_q      <= addr_d;
      sdram_req_q <= sdram_req_d;
      rfsh_req_q  <= rfsh_req_d;
      timeout_q   <= timeout_d;
      dout_q      <= dout_d;
      tcnt_q      <= tcnt_d;
      rwin_q      <= rwin_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) state_d = ST_IDLE;
    else begin
      case (state_q)
        ST_IDLE:  if (do_grant) state_d = ST_ISSUE;
                  else if (do_rfsh) state_d = ST_RFSH;
        ST_ISSUE: if (sd.sdram_ack) state_d = sd.data_rdy ? ST_IDLE : ST_WAIT;
        ST_WAIT:  if (sd.data_rdy || tout_hit) state_d = ST_IDLE;
        ST_RFSH:  if (sd.sdram_ack) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    grant_d     = grant_q;
    cl_ok_d     = '0;
    ptr_d       = ptr_q;
    addr_d      = addr_q;
    sdram_req_d = sdram_req_q;
    rfsh_req_d  = rfsh_req_q;
    timeout_d   = timeout_q;
    dout_d      = dout_q;
    tcnt_d      = tcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (do_grant) begin
          grant_d     = pick_grant;
          addr_d      = pick_addr;
          sdram_req_d = 1'b1;
          if (pick_type == GT_RR) ptr_d = oh2idx(8'(pick_grant));
        end
        if (do_rfsh) rfsh_req_d = 1'b1;
      end
      ST_ISSUE: begin
        if (sd.sdram_ack) begin
          sdram_req_d = 1'b0;
          tcnt_d      = '0;
          if (sd.data_rdy) begin
            dout_d  = sd.data_read;
            cl_ok_d = grant_q;
          end
        end
      end
      ST_WAIT: begin
        if (sd.data_rdy) begin
          dout_d  = sd.data_read;
          cl_ok_d = grant_q;
        end else if (tout_hit) timeout_d = 1'b1;
        else tcnt_d = tcnt_q + 8'd1;
      end
      ST_RFSH: if (sd.sdram_ack) rfsh_req_d = 1'b0;
      default: ;
    endcase
    if (flush) begin
      grant_d     = '0;
      cl_ok_d     = '0;
      ptr_d       = '0;
      sdram_req_d = 1'b0;
      rfsh_req_d  = 1'b0;
      timeout_d   = 1'b0;
    end
  end

  always_comb begin
    rwin_d = rwin_q;
    if (flush || !refresh_en || do_rfsh) rwin_d = '0;
    else if (rwin_q != 7'h7F) rwin_d = rwin_q + 7'd1;
  end

  assign cl_ok         = cl_ok_q;
  assign dout          = dout_q;
  assign timeout_err   = timeout_q;
  assign sd.sdram_req  = sdram_req_q;
  assign sd.sdram_addr = addr_q;
  assign sd.rfsh_req   = rfsh_req_q;

endmodule

// File: tb/tb_jtgng_sdram_arb.sv
// Directed bench for jtgng_sdram_arb with a simple 1-cycle-ack / 4-cycle-data controller model.
module tb_jtgng_sdram_arb;

  localparam int NC = 4;
  localparam int AW = 22;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             refresh_en = 1'b0;
  logic [NC-1:0]    cl_req = '0;
  logic [NC*AW-1:0] cl_addr;
  logic [NC-1:0]    cl_ok;
  logic [31:0]      dout;
  logic             timeout_err;

  jtgng_sdram_arb_if #(.AW(AW)) sd_if ();

  logic        man_ack = 1'b0, man_rdy = 1'b0;
  logic [31:0] man_data = '0;
  logic        c_ack = 1'b0, c_rdy = 1'b0;
  logic [31:0] c_data = '0;
  logic        ctl_en = 1'b0, same_cyc = 1'b0, fixed_en = 1'b0;
  logic [31:0] fixed_data = '0;

  assign sd_if.sdram_ack = man_ack | c_ack;
  assign sd_if.data_rdy  = man_rdy | c_rdy;
  assign sd_if.data_read = man_rdy ? man_data : c_data;

  logic [AW-1:0] addr_tab [NC];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ok_idx[$];
  logic [31:0] ok_dout[$];

  jtgng_sdram_arb #(.NC(NC), .AW(AW), .STARVE(8'd64), .TOUT(8'd32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .refresh_en  (refresh_en),
    .cl_req      (cl_req),
    .cl_addr     (cl_addr),
    .cl_ok       (cl_ok),
    .dout        (dout),
    .timeout_err (timeout_err),
    .sd          (sd_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic int count_of(input int c);
    int n = 0;
    foreach (ok_idx[i]) if (ok_idx[i] == c) n++;
    return n;
  endfunction

  function automatic logic [31:0] exp_data(input int c);
    logic [AW-1:0] a;
    a = addr_tab[c];
    return 32'hA500_0000 ^ 32'(a);
  endfunction

  task automatic wait_ok(input int n, input int bound, output int cycles);
    cycles = 0;
    while (ok_idx.size() < n && cycles < bound) begin
      @(negedge clk);
      cycles++;
    end
    chk("ok_wait", 32'(ok_idx.size()), 32'(n));
  endtask

  task automatic clear_log();
    ok_idx.delete();
    ok_dout.delete();
  endtask

  // Controller model: ack one cycle after seeing a request, data four cycles after ack
  initial begin : ctrl
    logic [31:0] d;
    forever begin
      @(negedge clk);
      if (ctl_en && sd_if.sdram_req) begin
        d = fixed_en ? fixed_data : (32'hA500_0000 ^ 32'(sd_if.sdram_addr));
        c_ack = 1'b1;
        if (same_cyc) begin
          c_rdy  = 1'b1;
          c_data = d;
        end
        @(negedge clk);
        c_ack = 1'b0;
        c_rdy = 1'b0;
        if (!same_cyc) begin
          repeat (3) @(negedge clk);
          c_rdy  = 1'b1;
          c_data = d;
          @(negedge clk);
          c_rdy = 1'b0;
        end
      end else if (ctl_en && sd_if.rfsh_req) begin
        c_ack = 1'b1;
        @(negedge clk);
        c_ack = 1'b0;
      end
    end
  end

  initial begin : mon
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < NC; i++) begin
        if (cl_ok[i]) begin
          ok_idx.push_back(i);
          ok_dout.push_back(dout);
          $display("cyc %0d ok client %0d dout %h", cyc, i, dout);
        end
      end
    end
  end

  initial begin : main
    int t, n0;
    int exp_rr [4] = '{1, 2, 1, 2};
    addr_tab = '{22'h0A1B2C, 22'h155AA5, 22'h2F0F0F, 22'h3C3C3C};
    for (int i = 0; i < NC; i++) cl_addr[i*AW +: AW] = addr_tab[i];

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_sdram_req", 32'(sd_if.sdram_req), 0);
    chk("rst_rfsh_req", 32'(sd_if.rfsh_req), 0);
    chk("rst_cl_ok", 32'(cl_ok), 0);
    chk("rst_dout", dout, 0);
    chk("rst_addr", 32'(sd_if.sdram_addr), 0);
    chk("rst_terr", 32'(timeout_err), 0);

    // Grant on the first edge after release
    ctl_en = 1'b1;
    cl_req = 4'b0001;
    rst_n  = 1'b1;
    @(negedge clk);
    chk("rel_req", 32'(sd_if.sdram_req), 1);
    chk("rel_addr", 32'(sd_if.sdram_addr), 32'(addr_tab[0]));
    cl_req = '0;
    wait_ok(1, 20, t);
    if (ok_idx.size() > 0) begin
      chk("rel_ok_idx", 32'(ok_idx[0]), 0);
      chk("rel_dout", ok_dout[0], exp_data(0));
    end
    repeat (4) @(negedge clk);

    // Round-robin between clients 1 and 2
    clear_log();
    cl_req = 4'b0110;
    wait_ok(4, 100, t);
    cl_req = '0;
    for (int i = 0; i < 4; i++) begin
      if (i < ok_idx.size()) begin
        chk("rr_idx", 32'(ok_idx[i]), 32'(exp_rr[i]));
        chk("rr_dout", ok_dout[i], exp_data(exp_rr[i]));
      end
    end
    repeat (12) @(negedge clk);

    // Client 0 hogs until client 3 starves
    clear_log();
    cl_req = 4'b1001;
    t = 0;
    while (count_of(3) == 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("st_c3_not_early", 32'(t >= 65), 1);
    chk("st_c3_not_late", 32'(t <= 77), 1);
    chk("st_c0_before", 32'(count_of(0) >= 8), 1);
    n0 = count_of(0);
    repeat (40) @(negedge clk);
    chk("st_c3_once", 32'(count_of(3)), 1);
    chk("st_c0_after", 32'(count_of(0) > n0), 1);
    cl_req = '0;
    repeat (12) @(negedge clk);

    // Ack and data together; request dropped while in flight
    clear_log();
    same_cyc   = 1'b1;
    fixed_en   = 1'b1;
    fixed_data = 32'hDEADBEEF;
    cl_req = 4'b0100;
    @(negedge clk);
    cl_req = '0;
    wait_ok(1, 10, t);
    chk("sc_latency", 32'(t), 1);
    if (ok_idx.size() > 0) begin
      chk("sc_idx", 32'(ok_idx[0]), 2);
      chk("sc_dout", ok_dout[0], 32'hDEADBEEF);
    end
    same_cyc = 1'b0;
    fixed_en = 1'b0;
    repeat (4) @(negedge clk);

    // Data timeout
    clear_log();
    ctl_en = 1'b0;
    cl_req = 4'b0001;
    @(negedge clk);
    chk("to_req", 32'(sd_if.sdram_req), 1);
    cl_req  = '0;
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    chk("to_req_drop", 32'(sd_if.sdram_req), 0);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 31) chk("to_early", 32'(timeout_err), 0);
      if (k == 32) chk("to_set", 32'(timeout_err), 1);
    end
    chk("to_no_ok", 32'(ok_idx.size()), 0);
    ctl_en = 1'b1;
    cl_req = 4'b0010;
    @(negedge clk);
    chk("to_idle_grant", 32'(sd_if.sdram_addr), 32'(addr_tab[1]));
    cl_req = '0;
    wait_ok(1, 20, t);
    if (ok_idx.size() > 0) chk("to_next_idx", 32'(ok_idx[0]), 1);
    chk("to_sticky", 32'(timeout_err), 1);
    repeat (4) @(negedge clk);

    // Flush during WAIT
    clear_log();
    ctl_en = 1'b0;
    cl_req = 4'b0100;
    @(negedge clk);
    chk("fl_addr", 32'(sd_if.sdram_addr), 32'(addr_tab[2]));
    cl_req  = '0;
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fl_terr_clr", 32'(timeout_err), 0);
    chk("fl_req", 32'(sd_if.sdram_req), 0);
    man_rdy  = 1'b1;
    man_data = 32'h1234_5678;
    @(negedge clk);
    man_rdy = 1'b0;
    repeat (3) @(negedge clk);
    chk("fl_no_ok", 32'(ok_idx.size()), 0);
    ctl_en = 1'b1;
    cl_req = 4'b1100;
    @(negedge clk);
    chk("fl_fresh_ptr", 32'(sd_if.sdram_addr), 32'(addr_tab[2]));
    cl_req = '0;
    wait_ok(1, 20, t);
    repeat (4) @(negedge clk);

    // Refresh with no requests
    ctl_en = 1'b0;
    refresh_en = 1'b1;
    @(negedge clk);
    chk("rf_req", 32'(sd_if.rfsh_req), 1);
    chk("rf_no_sdreq", 32'(sd_if.sdram_req), 0);
    repeat (3) @(negedge clk);
    chk("rf_hold", 32'(sd_if.rfsh_req), 1);
    man_ack = 1'b1;
    refresh_en = 1'b0;
    @(negedge clk);
    man_ack = 1'b0;
    chk("rf_drop", 32'(sd_if.rfsh_req), 0);
    repeat (2) @(negedge clk);

    // Refresh forced through saturating client traffic
    clear_log();
    ctl_en = 1'b1;
    cl_req = 4'b0010;
    refresh_en = 1'b1;
    t = 0;
    while (!sd_if.rfsh_req && t < 120) begin
      @(negedge clk);
      t++;
    end
    chk("rf_force_not_early", 32'(t >= 64), 1);
    chk("rf_force_not_late", 32'(t <= 72), 1);
    chk("rf_client_served", 32'(count_of(1) >= 8), 1);
    refresh_en = 1'b0;
    cl_req = '0;
    repeat (12) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtgng_sdram_arb.md
JTGNG_SDRAM_ARB -- requirements
Module: jtgng_sdram_arb

Interface
REQ-001 The block SHALL have parameter NC, default 4: number of ROM clients, range 2..8.
REQ-002 The block SHALL have parameter AW, default 22: SDRAM word address width.
REQ-003 The block SHALL have parameter STARVE, default 8'd64: wait cycles before a client is forced ahead.
REQ-004 The block SHALL have parameter TOUT, default 8'd32: cycles allowed from sdram_ack to data_rdy.
REQ-005 The block SHALL have port clk, input, 1: the single clock; all logic SHALL be on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-007 The block SHALL have port flush, input, 1: synchronous abort, driven from loop_rst | downloading.
REQ-008 The block SHALL have port refresh_en, input, 1: refresh window, high during vertical blank.
REQ-009 The block SHALL have port cl_req, input, NC: per-client request level.
REQ-010 The block SHALL have port cl_addr, input, NC*AW: per-client word address, with client i at slice [i*AW +: AW].
REQ-011 The block SHALL have port cl_ok, output, NC: one-cycle data-valid pulse to the owning client.
REQ-012 The block SHALL have port dout, output, 32: registered read data.
REQ-013 The block SHALL have port sdram_req, output, 1: request to the SDRAM controller.
REQ-014 The block SHALL have port sdram_addr, output, AW: registered address.
REQ-015 The block SHALL have port sdram_ack, input, 1: the controller accepted the request.
REQ-016 The block SHALL have port data_rdy, input, 1: read data valid on data_read.
REQ-017 The block SHALL have port data_read, input, 32: SDRAM read data.
REQ-018 The block SHALL have port rfsh_req, output, 1: asks the controller for an auto-refresh.
REQ-019 The block SHALL have port timeout_err, output, 1: sticky flag, cleared only by reset or flush.

Function
REQ-020 The block SHALL implement an FSM with states IDLE, ISSUE, WAIT, RFSH.
REQ-021 In IDLE with any cl_req bit set, the block SHALL select a winner, register sdram_addr and the grant one-hot, assert sdram_req and go to ISSUE, all in one cycle.
REQ-022 Winner selection priority SHALL be: (a) any client whose wait counter has reached STARVE, lowest index first; (b) client 0 when requesting; (c) clients 1..NC-1 round-robin, searching from the index after the last round-robin winner and wrapping from NC-1 to 1.
REQ-023 The round-robin pointer SHALL update only on a grant of type (c).
REQ-024 In ISSUE, when sdram_ack is high the block SHALL deassert sdram_req the same cycle and go to WAIT; sdram_req SHALL otherwise stay high with sdram_addr stable.
REQ-025 In WAIT, when data_rdy is high the block SHALL register data_read into dout, pulse cl_ok for the granted client one cycle later together with dout, and return to IDLE.
REQ-026 IDLE-to-IDLE occupancy SHALL be at least 3 cycles plus the controller latency; there SHALL be no back-to-back issue without passing through IDLE.
REQ-027 A client's 8-bit wait counter SHALL increment each cycle its request is high and it is not granted, SHALL saturate at 255, and SHALL clear when it is granted or its request drops.
REQ-028 In IDLE with refresh_en high and no starving client, the block SHALL go to RFSH and assert rfsh_req until sdram_ack, then return to IDLE.
REQ-029 Client requests SHALL take priority over refresh unless refresh_en has been high for 64 cycles without a refresh being issued.
REQ-030 In WAIT, if no data_rdy arrives within TOUT cycles of the ack, the block SHALL set timeout_err, issue no cl_ok, and return to IDLE.
REQ-031 A cl_req that drops while its access is in flight SHALL still complete that access; the resulting cl_ok SHALL still be pulsed.
REQ-032 Simultaneous sdram_ack and data_rdy in ISSUE SHALL be treated as ack followed immediately by data: the block SHALL go to IDLE and pulse cl_ok.
REQ-033 flush high SHALL, on that edge, force IDLE, drop sdram_req and rfsh_req, suppress any pending cl_ok, and clear the counters, the round-robin pointer and timeout_err.

Reset
REQ-034 On rst_n low the block SHALL asynchronously enter IDLE, with sdram_req=0, rfsh_req=0, cl_ok=0, dout=0, sdram_addr=0, timeout_err=0, wait counters=0 and round-robin pointer=0.
REQ-035 After reset release, the first grant SHALL be possible on the first edge that sees rst_n high.

Structure
REQ-036 The state encoding and the default STARVE/TOUT constants SHALL live in the shared package jtgng_sdram_pkg, reused by the SDRAM controller bench.
REQ-037 The winner selection SHALL be one combinational sub-module, jtgng_arb_pick (inputs: req, starve, pointer; outputs: one-hot grant, grant type).

Verification
REQ-038 Scenario: cl_req=4'b0110 held, no refresh, controller acking in 1 cycle with data in 4 -> grant order 1,2,1,2 and cl_ok pulses alternate.
REQ-039 Scenario: client 0 and client 3 both held -> client 0 served continuously until client 3's wait counter reaches 64, then client 3 is granted exactly once.
REQ-040 Scenario: in WAIT, data_rdy withheld for 40 cycles -> timeout_err=1 at cycle 32 after ack, no cl_ok, FSM in IDLE.
REQ-041 Scenario: flush pulsed during WAIT on client 2 -> a later data_rdy produces no cl_ok and the next grant follows fresh priority.
REQ-042 Scenario: refresh_en=1 with all requests low -> rfsh_req until ack; with client 1 saturating requests, a refresh is issued by cycle 64 of the window.
REQ-043 Scenario: sdram_ack and data_rdy in the same ISSUE cycle with data_read=32'hDEADBEEF -> next cycle cl_ok[granted]=1 and dout=32'hDEADBEEF.
